// File: rtl/lsq_issue_sched.sv
// Issue scheduler: four single-entry request slots feeding three LSQ ports.
// Grants are round-robin. Dependency-blocked requests are replayed after a back-off.
module lsq_issue_sched #(
  parameter int LSQ_W   = 6,
  parameter int ADDR_W  = 44,
  parameter int BACKOFF = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              except,
  input  logic              rq0_en,
  input  logic              rq1_en,
  input  logic              rq2_en,
  input  logic              rq3_en,
  input  logic [LSQ_W-1:0]  rq0_LSQ,
  input  logic [LSQ_W-1:0]  rq1_LSQ,
  input  logic [LSQ_W-1:0]  rq2_LSQ,
  input  logic [LSQ_W-1:0]  rq3_LSQ,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [ADDR_W-1:0] rq2_addr,
  input  logic [ADDR_W-1:0] rq3_addr,
  output logic [3:0]        rq_rdy,
  output logic              p0_en,
  output logic              p1_en,
  output logic              p2_en,
  output logic [LSQ_W-1:0]  p0_LSQ,
  output logic [LSQ_W-1:0]  p1_LSQ,
  output logic [LSQ_W-1:0]  p2_LSQ,
  output logic [ADDR_W-1:0] p0_lsaddr,
  output logic [ADDR_W-1:0] p1_lsaddr,
  output logic [ADDR_W-1:0] p2_lsaddr,
  input  logic [2:0]        has_dep,
  output logic              do_stall,
  output logic [7:0]        dbg_slot_state,
  output logic [1:0]        dbg_rr
);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_WAIT = 2'd1, S_ISSUED = 2'd2} slot_state_e;

  slot_state_e       st      [4];
  logic [LSQ_W-1:0]  s_lsq   [4];
  logic [ADDR_W-1:0] s_addr  [4];
  logic [3:0]        s_bo    [4];
  logic [1:0]        s_port  [4];
  logic [1:0]        rr;

  logic [2:0]        p_en_q;
  logic [LSQ_W-1:0]  p_lsq_q  [3];
  logic [ADDR_W-1:0] p_addr_q [3];

  logic [3:0]        rq_en_v;
  logic [LSQ_W-1:0]  rq_lsq_v  [4];
  logic [ADDR_W-1:0] rq_addr_v [4];

  assign rq_en_v      = {rq3_en, rq2_en, rq1_en, rq0_en};
  assign rq_lsq_v[0]  = rq0_LSQ;
  assign rq_lsq_v[1]  = rq1_LSQ;
  assign rq_lsq_v[2]  = rq2_LSQ;
  assign rq_lsq_v[3]  = rq3_LSQ;
  assign rq_addr_v[0] = rq0_addr;
  assign rq_addr_v[1] = rq1_addr;
  assign rq_addr_v[2] = rq2_addr;
  assign rq_addr_v[3] = rq3_addr;

  // Requester handshake: a request transfers on a clock edge where rqi_en and
  // rq_rdy[i] are both high and except is low. The requester holds rqi_en and
  // its payload until then.
  logic [3:0] acc, elig, res_hit, res_dep, busy_n;

  always_comb begin
    acc     = '0;
    elig    = '0;
    res_hit = '0;
    res_dep = '0;
    busy_n  = '0;
    for (int i = 0; i < 4; i++) begin
      acc[i]  = rq_en_v[i] && rq_rdy[i] && !except;
      elig[i] = (st[i] == S_WAIT) && (s_bo[i] == 4'd0);
      for (int k = 0; k < 3; k++) begin
        if (st[i] == S_ISSUED && s_port[i] == 2'(k) && p_en_q[k]) begin
          res_hit[i] = 1'b1;
          res_dep[i] = has_dep[k];
        end
      end
      busy_n[i] = acc[i] || (st[i] == S_WAIT) ||
                  (st[i] == S_ISSUED && (res_dep[i] || !res_hit[i]));
    end
  end

  // Round-robin scan from rr; the n-th eligible slot found takes port n.
  logic [3:0] gnt;
  logic [1:0] gnt_port  [4];
  logic [1:0] port_slot [3];
  logic [2:0] port_vld;
  logic [1:0] rr_n;
  logic [1:0] n_gnt;
  logic [1:0] idx;

  always_comb begin
    gnt      = '0;
    port_vld = '0;
    n_gnt    = '0;
    rr_n     = rr;
    idx      = '0;
    for (int i = 0; i < 4; i++) gnt_port[i] = '0;
    for (int k = 0; k < 3; k++) port_slot[k] = '0;
    if (!stall && !except) begin
      for (int j = 0; j < 4; j++) begin
        idx = rr + 2'(j);
        if (elig[idx] && n_gnt != 2'd3) begin
          gnt[idx]      = 1'b1;
          gnt_port[idx] = n_gnt;
          for (int k = 0; k < 3; k++) begin
            if (n_gnt == 2'(k)) begin
              port_slot[k] = idx;
              port_vld[k]  = 1'b1;
            end
          end
          rr_n  = idx + 2'd1;
          n_gnt = n_gnt + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        st[i]     <= S_EMPTY;
        s_lsq[i]  <= '0;
        s_addr[i] <= '0;
        s_bo[i]   <= '0;
        s_port[i] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        p_lsq_q[k]  <= '0;
        p_addr_q[k] <= '0;
      end
      rq_rdy   <= 4'b1111;
      rr       <= '0;
      p_en_q   <= '0;
      do_stall <= 1'b0;
    end else begin
      // Ready rises one cycle after a slot empties, but drops on the accept edge.
      for (int i = 0; i < 4; i++) rq_rdy[i] <= (st[i] == S_EMPTY) && !acc[i];
      if (except) begin
        for (int i = 0; i < 4; i++) st[i] <= S_EMPTY;
        p_en_q   <= '0;
        rr       <= '0;
        do_stall <= 1'b0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          case (st[i])
            S_EMPTY: begin
              if (acc[i]) begin
                st[i]     <= S_WAIT;
                s_bo[i]   <= 4'd0;
                s_lsq[i]  <= rq_lsq_v[i];
                s_addr[i] <= rq_addr_v[i];
              end
            end
            S_WAIT: begin
              if (gnt[i]) begin
                st[i]     <= S_ISSUED;
                s_port[i] <= gnt_port[i];
              end else if (s_bo[i] != 4'd0) begin
                s_bo[i] <= s_bo[i] - 4'd1;
              end
            end
            S_ISSUED: begin
              if (res_hit[i]) begin
                if (res_dep[i]) begin
                  st[i]   <= S_WAIT;
                  s_bo[i] <= 4'(BACKOFF);
                end else begin
                  st[i] <= S_EMPTY;
                end
              end
            end
            default: st[i] <= S_EMPTY;
          endcase
        end
        for (int k = 0; k < 3; k++) begin
          p_en_q[k] <= port_vld[k];
          if (port_vld[k]) begin
            p_lsq_q[k]  <= s_lsq[port_slot[k]];
            p_addr_q[k] <= s_addr[port_slot[k]];
          end
        end
        rr       <= rr_n;
        do_stall <= &busy_n;
      end
    end
  end

  assign p0_en          = p_en_q[0];
  assign p1_en          = p_en_q[1];
  assign p2_en          = p_en_q[2];
  assign p0_LSQ         = p_lsq_q[0];
  assign p1_LSQ         = p_lsq_q[1];
  assign p2_LSQ         = p_lsq_q[2];
  assign p0_lsaddr      = p_addr_q[0];
  assign p1_lsaddr      = p_addr_q[1];
  assign p2_lsaddr      = p_addr_q[2];
  assign dbg_slot_state = {st[3], st[2], st[1], st[0]};
  assign dbg_rr         = rr;

endmodule
